// File: rtl/crd_drop_pkg.sv
// Shared token encoding, FSM states and token classifiers for crd_drop_unit.
package crd_drop_pkg;

  localparam int TOKEN_W  = 17;
  localparam int CTRL_BIT = 16;
  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;

  typedef logic [TOKEN_W-1:0] token_t;

  typedef enum logic [1:0] {
    GET_OUTER,
    SCAN_INNER,
    EMIT,
    WAIT_DONE
  } state_e;

  function automatic logic is_ctrl(input token_t t);
    return t[CTRL_BIT];
  endfunction

  function automatic logic is_done(input token_t t);
    return t == DONE_TOKEN;
  endfunction

  // Any control value other than done behaves as a stop token.
  function automatic logic is_stop(input token_t t);
    return t[CTRL_BIT] && (t != DONE_TOKEN);
  endfunction

endpackage

// File: rtl/crd_drop_unit_stream_out_reg.sv
// One-entry registered output stage; reloads in the same cycle it drains for full throughput.
module stream_out_reg
  import crd_drop_pkg::*;
(
  input  logic   clk,
  input  logic   flush_i,
  input  logic   en_i,
  input  logic   gate_i,
  input  logic   load_i,
  input  token_t dat_i,
  output logic   can_load_o,
  output token_t dat_o,
  output logic   vld_o,
  input  logic   rdy_i
);

  logic   vld_q;
  token_t dat_q;
  logic   drain;

  assign drain      = en_i & vld_q & rdy_i;
  assign can_load_o = en_i & (~vld_q | rdy_i);

  always_ff @(posedge clk) begin
    if (flush_i) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else if (load_i) begin
      vld_q <= 1'b1;
      dat_q <= dat_i;
    end else if (drain) begin
      vld_q <= 1'b0;
    end
  end

  assign vld_o = vld_q & gate_i;
  assign dat_o = dat_q;

endmodule

// File: rtl/crd_drop_unit.sv
// Drops outer coordinates whose inner fiber holds only a stop token; inner stream passes through.
// Outputs are registered (1-cycle latency); an input is ready only when its target register can load.
module crd_drop_unit
  import crd_drop_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                clk,
  input  logic                flush,
  input  logic                clk_en,
  input  logic                tile_en,
  input  logic [DATA_WIDTH:0] coord_in_outer,
  input  logic                coord_in_outer_valid,
  output logic                coord_in_outer_ready,
  input  logic [DATA_WIDTH:0] coord_in_inner,
  input  logic                coord_in_inner_valid,
  output logic                coord_in_inner_ready,
  output logic [DATA_WIDTH:0] coord_out_outer,
  output logic                coord_out_outer_valid,
  input  logic                coord_out_outer_ready,
  output logic [DATA_WIDTH:0] coord_out_inner,
  output logic                coord_out_inner_valid,
  input  logic                coord_out_inner_ready
);

  state_e state_q;
  token_t coord_q;
  logic   seen_q;
  logic   err_q;
  logic   err_d;

  logic   en;
  logic   ol_can;
  logic   il_can;
  logic   ol_load;
  logic   il_load;
  token_t ol_dat;
  logic   outer_rdy;
  logic   inner_rdy;
  logic   outer_fire;
  logic   inner_fire;

  assign en = clk_en & tile_en & ~flush;

  always_comb begin
    outer_rdy = 1'b0;
    inner_rdy = 1'b0;
    ol_load   = 1'b0;
    il_load   = 1'b0;
    ol_dat    = coord_in_outer;
    unique case (state_q)
      GET_OUTER: begin
        if (coord_in_outer_valid) begin
          if (is_stop(coord_in_outer)) begin
            outer_rdy = ol_can;
            ol_load   = ol_can;
          end else begin
            outer_rdy = en;
          end
        end
      end
      SCAN_INNER: begin
        if (coord_in_inner_valid && !is_done(coord_in_inner)) begin
          inner_rdy = il_can;
          il_load   = il_can;
        end
      end
      EMIT: begin
        ol_dat  = coord_q;
        ol_load = seen_q & ol_can;
      end
      WAIT_DONE: begin
        if (coord_in_inner_valid) begin
          // Done is broadcast to both outputs, so it needs both registers free.
          if (is_done(coord_in_inner)) begin
            inner_rdy = il_can & ol_can;
            ol_load   = il_can & ol_can;
            il_load   = il_can & ol_can;
            ol_dat    = DONE_TOKEN;
          end else begin
            inner_rdy = il_can;
            il_load   = il_can;
          end
        end
      end
      default: ;
    endcase
  end

  assign outer_fire = coord_in_outer_valid & outer_rdy;
  assign inner_fire = coord_in_inner_valid & inner_rdy;

  assign err_d = err_q | (en && (state_q == SCAN_INNER) && coord_in_inner_valid
                          && is_done(coord_in_inner));

  assign coord_in_outer_ready = outer_rdy;
  assign coord_in_inner_ready = inner_rdy;

  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= GET_OUTER;
      coord_q <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      err_q <= err_d;
      unique case (state_q)
        GET_OUTER: begin
          if (outer_fire) begin
            if (!is_ctrl(coord_in_outer)) begin
              coord_q <= coord_in_outer;
              seen_q  <= 1'b0;
              state_q <= SCAN_INNER;
            end else if (is_done(coord_in_outer)) begin
              state_q <= WAIT_DONE;
            end
          end
        end
        SCAN_INNER: begin
          if (inner_fire) begin
            if (is_ctrl(coord_in_inner)) begin
              state_q <= EMIT;
            end else begin
              seen_q <= 1'b1;
            end
          end else if (coord_in_inner_valid && is_done(coord_in_inner)) begin
            // Done inside a fiber: leave it at the head for WAIT_DONE to forward.
            state_q <= WAIT_DONE;
          end
        end
        EMIT: begin
          if (!seen_q || ol_can) begin
            state_q <= GET_OUTER;
          end
        end
        WAIT_DONE: begin
          if (inner_fire && is_done(coord_in_inner)) begin
            state_q <= GET_OUTER;
          end
        end
        default: state_q <= GET_OUTER;
      endcase
    end
  end

  stream_out_reg u_outer_reg (
    .clk        (clk),
    .flush_i    (flush),
    .en_i       (en),
    .gate_i     (tile_en),
    .load_i     (ol_load),
    .dat_i      (ol_dat),
    .can_load_o (ol_can),
    .dat_o      (coord_out_outer),
    .vld_o      (coord_out_outer_valid),
    .rdy_i      (coord_out_outer_ready)
  );

  stream_out_reg u_inner_reg (
    .clk        (clk),
    .flush_i    (flush),
    .en_i       (en),
    .gate_i     (tile_en),
    .load_i     (il_load),
    .dat_i      (coord_in_inner),
    .can_load_o (il_can),
    .dat_o      (coord_out_inner),
    .vld_o      (coord_out_inner_valid),
    .rdy_i      (coord_out_inner_ready)
  );

endmodule

// File: tb/tb_crd_drop_unit.sv
// Self-checking bench for crd_drop_unit: vector table of streams with scoreboard queues.
module tb_crd_drop_unit;

  localparam int S0 = 'h10000;
  localparam int S1 = 'h10001;
  localparam int D  = 'h10100;
  localparam int X2 = 'h10200;
  localparam int NV = 6;

  typedef logic [11:0][16:0] tokv_t;
  typedef struct packed {
    int    n_oi;
    int    n_ii;
    int    n_oe;
    int    n_ie;
    tokv_t oi;
    tokv_t ii;
    tokv_t oe;
    tokv_t ie;
    int    opct;
    int    ipct;
    int    stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        flush = 1'b1;
  logic        clk_en = 1'b1;
  logic        tile_en = 1'b1;
  logic [16:0] coord_in_outer = '0;
  logic        coord_in_outer_valid = 1'b0;
  logic        coord_in_outer_ready;
  logic [16:0] coord_in_inner = '0;
  logic        coord_in_inner_valid = 1'b0;
  logic        coord_in_inner_ready;
  logic [16:0] coord_out_outer;
  logic        coord_out_outer_valid;
  logic        coord_out_outer_ready = 1'b0;
  logic [16:0] coord_out_inner;
  logic        coord_out_inner_valid;
  logic        coord_out_inner_ready = 1'b0;

  logic [16:0] src_o[$];
  logic [16:0] src_i[$];
  logic [16:0] exp_o[$];
  logic [16:0] exp_i[$];
  int          in_st[$];
  int          out_st[$];

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int cyc = 0;
  int tc  = 0;
  int opct = 100;
  int ipct = 100;
  int inner_stall = 0;
  logic rdy_block = 1'b0;

  vec_t vecs[NV];

  always #5 clk = ~clk;

  crd_drop_unit #(.DATA_WIDTH(16)) dut (
    .clk                   (clk),
    .flush                 (flush),
    .clk_en                (clk_en),
    .tile_en               (tile_en),
    .coord_in_outer        (coord_in_outer),
    .coord_in_outer_valid  (coord_in_outer_valid),
    .coord_in_outer_ready  (coord_in_outer_ready),
    .coord_in_inner        (coord_in_inner),
    .coord_in_inner_valid  (coord_in_inner_valid),
    .coord_in_inner_ready  (coord_in_inner_ready),
    .coord_out_outer       (coord_out_outer),
    .coord_out_outer_valid (coord_out_outer_valid),
    .coord_out_outer_ready (coord_out_outer_ready),
    .coord_out_inner       (coord_out_inner),
    .coord_out_inner_valid (coord_out_inner_valid),
    .coord_out_inner_ready (coord_out_inner_ready)
  );

  function automatic tokv_t mk(input int t0 = 0, input int t1 = 0, input int t2 = 0,
                               input int t3 = 0, input int t4 = 0, input int t5 = 0,
                               input int t6 = 0, input int t7 = 0, input int t8 = 0,
                               input int t9 = 0, input int t10 = 0, input int t11 = 0);
    tokv_t r;
    r[0] = t0[16:0];  r[1] = t1[16:0];   r[2] = t2[16:0];   r[3] = t3[16:0];
    r[4] = t4[16:0];  r[5] = t5[16:0];   r[6] = t6[16:0];   r[7] = t7[16:0];
    r[8] = t8[16:0];  r[9] = t9[16:0];   r[10] = t10[16:0]; r[11] = t11[16:0];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
  endtask

  // One clock: drive at negedge, sample 1ns later, commit pops at posedge.
  task automatic cycle();
    logic fo, fi, so, si;
    @(negedge clk);
    coord_in_outer_valid  = (src_o.size() > 0);
    coord_in_outer        = (src_o.size() > 0) ? src_o[0] : 17'h0;
    coord_in_inner_valid  = (src_i.size() > 0);
    coord_in_inner        = (src_i.size() > 0) ? src_i[0] : 17'h0;
    coord_out_outer_ready = !rdy_block && ($urandom_range(99) < opct);
    coord_out_inner_ready = !rdy_block && (tc >= inner_stall) && ($urandom_range(99) < ipct);
    #1;
    fo = coord_in_outer_valid & coord_in_outer_ready;
    fi = coord_in_inner_valid & coord_in_inner_ready;
    so = coord_out_outer_valid & coord_out_outer_ready & clk_en & tile_en;
    si = coord_out_inner_valid & coord_out_inner_ready & clk_en & tile_en;
    if (so) begin
      if (exp_o.size() == 0) begin
        tot_cnt++;
        $display("FAIL outer extra: got %h, required no token (cycle %0d)", coord_out_outer, cyc);
      end else check("outer token", {15'h0, coord_out_outer}, {15'h0, exp_o.pop_front()});
    end
    if (si) begin
      out_st.push_back(cyc);
      if (exp_i.size() == 0) begin
        tot_cnt++;
        $display("FAIL inner extra: got %h, required no token (cycle %0d)", coord_out_inner, cyc);
      end else check("inner token", {15'h0, coord_out_inner}, {15'h0, exp_i.pop_front()});
    end
    if (fi) in_st.push_back(cyc);
    if (coord_out_inner_valid && !coord_out_inner_ready)
      check("inner in rdy while stalled", {31'h0, coord_in_inner_ready}, 32'h0);
    if (coord_out_outer_valid && !coord_out_outer_ready && coord_in_outer_valid &&
        coord_in_outer[16] && coord_in_outer != D[16:0])
      check("outer in rdy while stalled", {31'h0, coord_in_outer_ready}, 32'h0);
    if (flush)
      check("in rdy during flush", {30'h0, coord_in_outer_ready, coord_in_inner_ready}, 32'h0);
    if (!tile_en) begin
      check("gated in rdy", {30'h0, coord_in_outer_ready, coord_in_inner_ready}, 32'h0);
      check("gated out vld", {30'h0, coord_out_outer_valid, coord_out_inner_valid}, 32'h0);
    end
    @(posedge clk);
    if (fo) void'(src_o.pop_front());
    if (fi) void'(src_i.pop_front());
    cyc++;
    tc++;
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_o.size() > 0 || exp_i.size() > 0) && n < 600) begin
      cycle();
      n++;
    end
    repeat (4) cycle();
    check({name, " outer tokens missing"}, exp_o.size(), 0);
    check({name, " inner tokens missing"}, exp_i.size(), 0);
    check({name, " inputs unconsumed"}, src_o.size() + src_i.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0].oi = mk(1, 2, 3, S0, D);                   vecs[0].n_oi = 5;
    vecs[0].ii = mk(5, S0, S0, 7, 8, S1, D);           vecs[0].n_ii = 7;
    vecs[0].oe = mk(1, 3, S0, D);                      vecs[0].n_oe = 4;
    vecs[0].opct = 100; vecs[0].ipct = 100; vecs[0].stall = 0;

    vecs[1].oi = mk(4, 9, S0, D);                      vecs[1].n_oi = 4;
    vecs[1].ii = mk(S0, S1, D);                        vecs[1].n_ii = 3;
    vecs[1].oe = mk(S0, D);                            vecs[1].n_oe = 2;
    vecs[1].opct = 100; vecs[1].ipct = 100; vecs[1].stall = 0;

    vecs[2] = vecs[0];
    vecs[2].opct = 50; vecs[2].ipct = 100; vecs[2].stall = 5;

    vecs[3].oi = mk(1, 2, 3, S0, D, 4, 9, S0, D);      vecs[3].n_oi = 9;
    vecs[3].ii = mk(5, S0, S0, 7, 8, S1, D, S0, S1, D); vecs[3].n_ii = 10;
    vecs[3].oe = mk(1, 3, S0, D, S0, D);               vecs[3].n_oe = 6;
    vecs[3].opct = 70; vecs[3].ipct = 70; vecs[3].stall = 0;

    vecs[4].oi = mk(0, S0, D);                         vecs[4].n_oi = 3;
    vecs[4].ii = mk(1, 2, 3, 4, 5, 6, 7, 8, S0, D);    vecs[4].n_ii = 10;
    vecs[4].oe = mk(0, S0, D);                         vecs[4].n_oe = 3;
    vecs[4].opct = 100; vecs[4].ipct = 100; vecs[4].stall = 0;

    vecs[5].oi = mk(6, S1, D);                         vecs[5].n_oi = 3;
    vecs[5].ii = mk(X2, D);                            vecs[5].n_ii = 2;
    vecs[5].oe = mk(S1, D);                            vecs[5].n_oe = 2;
    vecs[5].opct = 100; vecs[5].ipct = 100; vecs[5].stall = 0;

    for (int k = 0; k < NV; k++) begin
      vecs[k].ie   = vecs[k].ii;
      vecs[k].n_ie = vecs[k].n_ii;
    end

    // Reset: flush held with a coordinate offered on both inputs.
    coord_in_outer = 17'd5; coord_in_outer_valid = 1'b1;
    coord_in_inner = 17'd6; coord_in_inner_valid = 1'b1;
    coord_out_outer_ready = 1'b1; coord_out_inner_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset in rdy", {30'h0, coord_in_outer_ready, coord_in_inner_ready}, 32'h0);
    check("reset out vld", {30'h0, coord_out_outer_valid, coord_out_inner_valid}, 32'h0);
    check("reset outer dat", {15'h0, coord_out_outer}, 32'h0);
    check("reset inner dat", {15'h0, coord_out_inner}, 32'h0);
    flush = 1'b0;
    coord_in_outer_valid = 1'b0;
    coord_in_inner_valid = 1'b0;

    for (int k = 0; k < NV; k++) begin
      opct = vecs[k].opct; ipct = vecs[k].ipct; inner_stall = vecs[k].stall; tc = 0;
      in_st.delete(); out_st.delete();
      for (int j = 0; j < vecs[k].n_oi; j++) src_o.push_back(vecs[k].oi[j]);
      for (int j = 0; j < vecs[k].n_ii; j++) src_i.push_back(vecs[k].ii[j]);
      for (int j = 0; j < vecs[k].n_oe; j++) exp_o.push_back(vecs[k].oe[j]);
      for (int j = 0; j < vecs[k].n_ie; j++) exp_i.push_back(vecs[k].ie[j]);
      drain($sformatf("vec%0d", k));
      if (k == 4) begin
        check("thru inner count", {31'h0, out_st.size() >= 9}, 32'h1);
        if (out_st.size() > 0 && in_st.size() > 0)
          check("thru latency", out_st[0] - in_st[0], 1);
        for (int j = 0; j < 8 && j + 1 < out_st.size(); j++)
          check("thru back-to-back", out_st[j+1] - out_st[j], 1);
      end
    end

    // tile_en low with a full outer register: valids and readys forced low, state held.
    opct = 0; ipct = 0; inner_stall = 0; tc = 0;
    src_o.push_back(S0[16:0]); src_o.push_back(D[16:0]); src_i.push_back(D[16:0]);
    exp_o.push_back(S0[16:0]); exp_o.push_back(D[16:0]); exp_i.push_back(D[16:0]);
    repeat (3) cycle();
    tile_en = 1'b0;
    repeat (3) cycle();
    tile_en = 1'b1;
    opct = 100; ipct = 100;
    drain("tile_en");

    // Flush while scanning an inner fiber, then a fresh tile.
    in_st.delete();
    src_o.push_back(17'd1); src_o.push_back(S0[16:0]); src_o.push_back(D[16:0]);
    for (int j = 5; j <= 7; j++) src_i.push_back(17'(j));
    src_i.push_back(S0[16:0]); src_i.push_back(D[16:0]);
    exp_o.push_back(17'd1); exp_o.push_back(S0[16:0]); exp_o.push_back(D[16:0]);
    for (int j = 5; j <= 7; j++) exp_i.push_back(17'(j));
    exp_i.push_back(S0[16:0]); exp_i.push_back(D[16:0]);
    for (int n = 0; n < 50 && in_st.size() == 0; n++) cycle();
    check("flush reached scan", {31'h0, in_st.size() > 0}, 32'h1);
    flush = 1'b1; rdy_block = 1'b1;
    cycle();
    flush = 1'b0; rdy_block = 1'b0;
    src_o.delete(); src_i.delete(); exp_o.delete(); exp_i.delete();
    coord_in_outer_valid = 1'b0; coord_in_inner_valid = 1'b0;
    @(negedge clk);
    #1;
    check("post-flush out vld", {30'h0, coord_out_outer_valid, coord_out_inner_valid}, 32'h0);
    src_o.push_back(17'd2); src_o.push_back(S0[16:0]); src_o.push_back(D[16:0]);
    src_i.push_back(17'd3); src_i.push_back(S1[16:0]); src_i.push_back(D[16:0]);
    exp_o.push_back(17'd2); exp_o.push_back(S0[16:0]); exp_o.push_back(D[16:0]);
    exp_i.push_back(17'd3); exp_i.push_back(S1[16:0]); exp_i.push_back(D[16:0]);
    drain("after flush");

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/crd_drop_unit.md
Name: crd_drop_unit

Overview:
- Sparse-stream stage directly downstream of intersect_unit.
- Consumes the outer-level coordinate stream and the inner-level coordinate stream that intersect_unit produces.
- Removes every outer coordinate whose inner fiber is empty, i.e. the inner fiber contains only a stop token.
- Passes the inner stream through unchanged, so later stages (reducers, writers) never see empty fibers.

Parameters:
DATA_WIDTH, 16, payload bits; token width is DATA_WIDTH+1, with the MSB as the control flag.

Ports:
clk  in  1  clock
flush  in  1  synchronous active-high reset; clears all state
clk_en  in  1  clock enable; when 0, all state holds
tile_en  in  1  when 0, all ready and valid outputs are forced to 0 and state holds
coord_in_outer  in  17  outer token stream
coord_in_outer_valid  in  1  producer has token
coord_in_outer_ready  out  1  block accepts outer token
coord_in_inner  in  17  inner token stream
coord_in_inner_valid  in  1  producer has token
coord_in_inner_ready  out  1  block accepts inner token
coord_out_outer  out  17  filtered outer stream
coord_out_outer_valid  out  1  outer output valid
coord_out_outer_ready  in  1  consumer accepts outer output
coord_out_inner  out  17  inner pass-through stream
coord_out_inner_valid  out  1  inner output valid
coord_out_inner_ready  in  1  consumer accepts inner output

Behaviour:
- Token encoding:
  - bit16=0: coordinate.
  - bit16=1 with bits[9:8]=00: stop token, level in bits[7:0] (S0=0x10000, S1=0x10001).
  - 0x10100: done token.
  - Any other control value is forwarded as a stop token.
- Handshake: a transfer occurs on a cycle where valid & ready & clk_en & tile_en.
- Output registers:
  - Each output has a 1-entry register (data, valid).
  - It loads when empty, or when full and being drained that same cycle (full throughput).
  - Latency is 1 cycle from input transfer to output valid.
  - An input ready is asserted only when its target output register can load this cycle.
- Reset (flush=1 at a clk edge):
  - Both output valids = 0, output data = 0.
  - State = GET_OUTER; latched outer coordinate = 0; seen = 0.
  - Input readys are 0 during the flush cycle.
- FSM, state GET_OUTER (only the outer input may be ready):
  - Head is a coordinate: latch it, clear seen, pop, go to SCAN_INNER.
  - Head is a stop token: forward it to the outer output, stay.
  - Head is done: pop, go to WAIT_DONE.
- FSM, state SCAN_INNER (only the inner input may be ready):
  - Every inner token is forwarded to the inner output.
  - A coordinate sets seen=1.
  - A stop token goes to EMIT.
  - A done token here is a protocol error: raise the sticky internal flag err, do not pop, go to WAIT_DONE.
- FSM, state EMIT:
  - seen=1: drive the latched coordinate into the outer register (waits on backpressure), then go to GET_OUTER.
  - seen=0: drop it; next cycle is GET_OUTER with no output.
- FSM, state WAIT_DONE:
  - Forward all inner tokens until inner done is at the head.
  - Then, in the same cycle only when both output registers can load, pop inner done and load done into both outputs.
  - Go to GET_OUTER to serve the next tile.
- Boundary cases:
  - Outer fiber whose coordinates are all dropped: its stop token is still emitted.
  - Back-to-back empty fibers are handled.
  - An inner stop arriving the same cycle as a full outer register that is draining is accepted.
  - Outer stop tokens never wait on the inner stream.
- Ordering: output order on each stream equals input order minus dropped coordinates.

Decomposition:
- Package crd_drop_pkg:
  - TOKEN_W = 17, CTRL_BIT = 16, DONE_TOKEN = 17'h10100.
  - State enum {GET_OUTER, SCAN_INNER, EMIT, WAIT_DONE}.
  - Functions is_ctrl / is_stop / is_done.
- One sub-module: stream_out_reg, the 1-entry registered output with valid/ready, instantiated twice.

Test Plan:
- Basic filter:
  - Stimulus: outer 1,2,3,S0,D; inner 5,S0,S0,7,8,S1,D.
  - Required: outer out 1,3,S0,D; inner out identical to inner in.
- All empty:
  - Stimulus: outer 4,9,S0,D; inner S0,S1,D.
  - Required: outer out S0,D; inner out S0,S1,D.
- Backpressure:
  - Stimulus: basic-filter streams with coord_out_outer_ready toggled randomly at 50% and inner ready held 0 for 5 cycles.
  - Required: identical output sequences, no token lost or duplicated, input readys deassert while outputs are stalled.
- Flush mid-stream:
  - Stimulus: assert flush for 1 cycle while in SCAN_INNER.
  - Required: both output valids 0 next cycle; the following tile (outer 2,S0,D; inner 3,S1,D) yields outer 2,S0,D.
- Multi-tile:
  - Stimulus: two tiles back to back (TX_NUM=2).
  - Required: two done tokens on each output, each aligned after its tile's tokens.
- Throughput:
  - Stimulus: all readys held 1; inner 1..8,S0,D; outer 0,S0,D.
  - Required: inner out emits one token per cycle after 1-cycle latency.
